// File: rtl/write_queued_if.sv
// Store port of the writeback stage: queue head presented to memory with a
// valid/accept handshake.
interface write_queued_if #(
    parameter int W = 32
);
    logic         mem_request;
    logic [W-1:0] mem_address;
    logic [W-1:0] mem_data;
    logic         mem_accept;

    modport master (
        output mem_request,
        output mem_address,
        output mem_data,
        input  mem_accept
    );

    modport slave (
        input  mem_request,
        input  mem_address,
        input  mem_data,
        output mem_accept
    );
endinterface

// File: rtl/write_queued.sv
// Writeback stage: commits the register view (including register-pair upper
// half, flags field and next PC) every accepted cycle, and buffers stores in
// an in-order FIFO drained through the memory handshake.
module write_queued #(
    parameter int W           = 32,
    parameter int NR          = 32,
    parameter int DEPTH       = 4,
    parameter int FLAGS_INDEX = NR - 2,
    parameter int PC_INDEX    = NR - 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       is_valid,
    output logic                       hold,
    input  logic [$clog2(NR)-1:0]      destination_register,
    input  logic [W-1:0]               destination_value,
    input  logic [W-1:0]               upper_value,
    input  logic                       has_upper_value,
    input  logic                       is_writing_memory,
    input  logic [W-1:0]               adjustment_value,
    input  logic [3:0]                 flags,
    input  logic [W-1:0]               pc,
    input  logic [W-1:0]               next_pc,
    input  logic                       has_flushed_in,
    output logic                       has_flushed,
    input  logic [NR*W-1:0]            input_registers,
    output logic [NR*W-1:0]            output_registers,
    write_queued_if.master             mem,
    output logic [$clog2(DEPTH+1)-1:0] queue_count,
    output logic                       feedback_is_valid,
    output logic [$clog2(NR)-1:0]      feedback_index,
    output logic [W-1:0]               feedback_value,
    output logic [W-1:0]               feedback_upper_value,
    output logic                       feedback_has_upper_value
);
    localparam int RW = $clog2(NR);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // Store address is base plus offset, wrapping modulo 2^W.
    function automatic logic [W-1:0] add_wrap(input logic [W-1:0] a, input logic [W-1:0] b);
        return a + b;
    endfunction

    // Replace the 4-bit flag field (bits 30:27) of the flags register.
    function automatic logic [W-1:0] merge_flags(input logic [W-1:0] r, input logic [3:0] f);
        logic [W-1:0] m;
        m        = r;
        m[30:27] = f;
        return m;
    endfunction

    logic [W-1:0]  view_p0 [NR];
    logic [W-1:0]  pc_next_p0;
    logic [RW:0]   upper_index_p0;
    logic [W-1:0]  regs_p1 [NR];
    logic          has_flushed_p1;
    logic [W-1:0]  addr_q [DEPTH];
    logic [W-1:0]  data_q [DEPTH];
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    logic [CW-1:0] count_p1;
    logic          full;
    logic          pop;
    logic          push;
    logic          accepted;

    // ---- stage p0: combinational register view, handshake and forwarding ----
    assign full     = (count_p1 == CW'(DEPTH));
    assign pop      = mem.mem_request && mem.mem_accept;
    assign hold     = reset_n && is_valid && is_writing_memory && full && !mem.mem_accept;
    assign accepted = is_valid && !hold;
    assign push     = accepted && is_writing_memory;

    assign feedback_is_valid        = is_valid && !is_writing_memory;
    assign feedback_index           = destination_register;
    assign feedback_value           = destination_value;
    assign feedback_upper_value     = upper_value;
    assign feedback_has_upper_value = has_upper_value;

    assign pc_next_p0 = (!is_writing_memory && destination_register == RW'(PC_INDEX))
                        ? destination_value : next_pc;

    // Build the working register view; upper write falls off naturally past NR-1.
    always_comb begin
        upper_index_p0 = {1'b0, destination_register} + (RW+1)'(1);
        for (int i = 0; i < NR; i++) begin
            if (i == 0)
                view_p0[i] = '0;
            else if (i == PC_INDEX)
                view_p0[i] = pc;
            else if (!is_writing_memory && destination_register == RW'(i))
                view_p0[i] = destination_value;
            else if (i == FLAGS_INDEX)
                view_p0[i] = merge_flags(input_registers[i*W +: W], flags);
            else if (!is_writing_memory && has_upper_value && upper_index_p0 == (RW+1)'(i))
                view_p0[i] = upper_value;
            else
                view_p0[i] = input_registers[i*W +: W];
        end
    end

    // ---- stage p1: committed register file and flush marker ----
    // Commit the view when accepted; an idle cycle only advances the PC.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) regs_p1[i] <= '0;
            has_flushed_p1 <= 1'b0;
        end else if (!is_valid) begin
            regs_p1[PC_INDEX] <= next_pc;
            has_flushed_p1    <= 1'b0;
        end else if (!hold) begin
            for (int i = 0; i < NR; i++)
                regs_p1[i] <= (i == PC_INDEX) ? pc_next_p0 : view_p0[i];
            has_flushed_p1 <= has_flushed_in;
        end
    end

    // Flatten the committed register file onto the output bus.
    always_comb begin
        for (int i = 0; i < NR; i++) output_registers[i*W +: W] = regs_p1[i];
    end

    assign has_flushed = has_flushed_p1;

    // FIFO pointers and occupancy; reset discards all queued stores.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_p1  <= '0;
            tail_p1  <= '0;
            count_p1 <= '0;
        end else begin
            if (push) tail_p1 <= tail_p1 + PW'(1);
            if (pop)  head_p1 <= head_p1 + PW'(1);
            if (push && !pop)
                count_p1 <= count_p1 + CW'(1);
            else if (pop && !push)
                count_p1 <= count_p1 - CW'(1);
        end
    end

    // FIFO storage; contents are meaningless unless counted as occupied.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_p1] <= add_wrap(view_p0[destination_register], adjustment_value);
            data_q[tail_p1] <= destination_value;
        end
    end

    assign mem.mem_request = (count_p1 != '0);
    assign mem.mem_address = addr_q[head_p1];
    assign mem.mem_data    = data_q[head_p1];
    assign queue_count     = count_p1;
endmodule

// File: tb/tb_write_queued.sv
// Randomised and directed bench for write_queued: stores are predicted into a
// scoreboard queue at issue time and checked by an independent pop monitor.
`timescale 1ns/1ps
module tb_write_queued;
    localparam int W = 32, NR = 32, DEPTH = 4, FL = NR - 2, PCI = NR - 1;
    localparam int RW = 5, CW = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          is_valid, hold, has_upper_value, is_writing_memory;
    logic [RW-1:0] destination_register, feedback_index;
    logic [W-1:0]  destination_value, upper_value, adjustment_value, pc, next_pc;
    logic [3:0]    flags;
    logic          has_flushed_in, has_flushed;
    logic [NR*W-1:0] input_registers, output_registers;
    logic [CW-1:0] queue_count;
    logic          feedback_is_valid, feedback_has_upper_value;
    logic [W-1:0]  feedback_value, feedback_upper_value;

    write_queued_if #(.W(W)) mem_if ();

    write_queued #(.W(W), .NR(NR), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .is_valid(is_valid), .hold(hold),
        .destination_register(destination_register), .destination_value(destination_value),
        .upper_value(upper_value), .has_upper_value(has_upper_value),
        .is_writing_memory(is_writing_memory), .adjustment_value(adjustment_value),
        .flags(flags), .pc(pc), .next_pc(next_pc), .has_flushed_in(has_flushed_in),
        .has_flushed(has_flushed), .input_registers(input_registers),
        .output_registers(output_registers), .mem(mem_if), .queue_count(queue_count),
        .feedback_is_valid(feedback_is_valid), .feedback_index(feedback_index),
        .feedback_value(feedback_value), .feedback_upper_value(feedback_upper_value),
        .feedback_has_upper_value(feedback_has_upper_value)
    );

    typedef struct packed { logic [W-1:0] addr; logic [W-1:0] data; } store_t;

    logic [W-1:0] rf_in    [NR];
    logic [W-1:0] exp_regs [NR];
    logic         exp_flushed = 1'b0;
    store_t       sb[$];
    logic [W-1:0] seen[$];
    int errors = 0, checks = 0;

    always_comb begin
        for (int i = 0; i < NR; i++) input_registers[i*W +: W] = rf_in[i];
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name);
        int bad = -1;
        for (int i = 0; i < NR; i++)
            if (bad < 0 && output_registers[i*W +: W] !== exp_regs[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s regs: r%0d got %h expected %h", name, bad,
                     output_registers[bad*W +: W], exp_regs[bad]);
        end
    endtask

    // Store monitor: every pop must match the oldest predicted store.
    always @(negedge clock) begin
        if (reset_n && mem_if.mem_request && mem_if.mem_accept) begin
            seen.push_back(mem_if.mem_address);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected pop: got address %h expected no entry", mem_if.mem_address);
            end else begin
                store_t e;
                e = sb.pop_front();
                check("store address", mem_if.mem_address, e.addr);
                check("store data", mem_if.mem_data, e.data);
            end
        end
    end

    task automatic drive(input logic v, input logic st, input int d, input logic [W-1:0] dv,
                         input logic [W-1:0] up, input logic hu, input logic [W-1:0] adj,
                         input logic [3:0] fl, input logic [W-1:0] npc, input logic fi,
                         input logic acc);
        is_valid = v; is_writing_memory = st; destination_register = RW'(d);
        destination_value = dv; upper_value = up; has_upper_value = hu;
        adjustment_value = adj; flags = fl; next_pc = npc; pc = npc - 32'd4;
        has_flushed_in = fi; mem_if.mem_accept = acc;
    endtask

    // One clock of the reference model: predicts hold, the committed file and any store.
    task automatic cycle(input string name);
        logic [W-1:0] v [NR];
        logic         exp_hold;
        store_t       s;
        int           d;
        #1;
        d = int'(destination_register);
        exp_hold = is_valid && is_writing_memory && (sb.size() == DEPTH) && !mem_if.mem_accept;
        check({name, " hold"}, W'(hold), W'(exp_hold));
        check({name, " count"}, W'(queue_count), W'(sb.size()));
        check({name, " mem_request"}, W'(mem_if.mem_request), W'(sb.size() != 0));
        check({name, " fb_valid"}, W'(feedback_is_valid), W'(is_valid && !is_writing_memory));
        if (!is_valid) begin
            exp_regs[PCI] = next_pc;
            exp_flushed = 1'b0;
        end else if (!exp_hold) begin
            v = rf_in;
            v[FL][30:27] = flags;
            if (!is_writing_memory) begin
                if (has_upper_value && d + 1 < NR && d + 1 != FL && d + 1 != PCI)
                    v[d+1] = upper_value;
                v[d] = destination_value;
            end
            v[0] = '0;
            v[PCI] = pc;
            if (is_writing_memory) begin
                s.addr = v[d] + adjustment_value;
                s.data = destination_value;
                sb.push_back(s);
            end
            exp_regs = v;
            exp_regs[PCI] = (!is_writing_memory && d == PCI) ? destination_value : next_pc;
            exp_flushed = has_flushed_in;
        end
        @(posedge clock);
        #1;
        check_regs(name);
        check({name, " has_flushed"}, W'(has_flushed), W'(exp_flushed));
    endtask

    task automatic alu(input int d, input logic [W-1:0] dv, input logic [W-1:0] up,
                       input logic hu, input logic [3:0] fl, input logic [W-1:0] npc);
        rf_in = exp_regs;
        drive(1'b1, 1'b0, d, dv, up, hu, '0, fl, npc, 1'b0, 1'b0);
        cycle("alu");
    endtask

    task automatic store(input int base, input logic [W-1:0] adj, input logic [W-1:0] dat,
                         input logic [W-1:0] npc, input logic acc);
        rf_in = exp_regs;
        drive(1'b1, 1'b1, base, dat, '0, 1'b0, adj, 4'h0, npc, 1'b0, acc);
        cycle("store");
    endtask

    task automatic idle(input logic acc);
        rf_in = exp_regs;
        drive(1'b0, 1'b0, 0, '0, '0, 1'b0, '0, 4'h0, exp_regs[PCI] + 32'd4, 1'b0, acc);
        cycle("idle");
    endtask

    logic [W-1:0] exp_seen [5];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_seen = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        for (int i = 0; i < NR; i++) begin rf_in[i] = '0; exp_regs[i] = '0; end
        drive(1'b0, 1'b0, 0, '0, '0, 1'b0, '0, 4'h0, '0, 1'b0, 1'b0);

        // Reset state
        #3;
        check_regs("reset");
        check("reset count", W'(queue_count), '0);
        check("reset mem_request", W'(mem_if.mem_request), '0);
        check("reset has_flushed", W'(has_flushed), '0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        // ALU write and register pairs
        alu(5, 32'h1234, '0, 1'b0, 4'h0, 32'h104);
        check("r5", output_registers[5*W +: W], 32'h1234);
        check("pc after alu", output_registers[PCI*W +: W], 32'h104);
        check("r0", output_registers[0 +: W], '0);
        alu(6, 32'hA, 32'hB, 1'b1, 4'h0, 32'h108);
        check("r6", output_registers[6*W +: W], 32'hA);
        check("r7", output_registers[7*W +: W], 32'hB);
        alu(FL - 1, 32'h55, 32'h77, 1'b1, 4'hA, 32'h10C);
        check("r29", output_registers[(FL-1)*W +: W], 32'h55);
        check("flags reg", output_registers[FL*W +: W], 32'h5000_0000);

        // Fill the queue, stall, then push with a simultaneous pop
        alu(2, 32'h100, '0, 1'b0, 4'h0, 32'h110);
        seen.delete();
        for (int k = 0; k < 4; k++)
            store(2, 32'(4 * k), 32'hD0 + 32'(k), 32'h114 + 32'(4 * k), 1'b0);
        check("full count", W'(queue_count), 32'd4);
        rf_in = exp_regs;
        drive(1'b1, 1'b1, 2, 32'hD4, '0, 1'b0, 32'd16, 4'h0, 32'h124, 1'b0, 1'b0);
        #1;
        check("fifth hold", W'(hold), 32'd1);
        cycle("held");
        check("held pc", output_registers[PCI*W +: W], 32'h120);
        check("held count", W'(queue_count), 32'd4);
        store(2, 32'd16, 32'hD4, 32'h124, 1'b1);
        check("push+pop pc", output_registers[PCI*W +: W], 32'h124);

        // Drain in order
        for (int k = 0; k < 6; k++) idle(1'b1);
        check("drained count", W'(queue_count), '0);
        check("drained request", W'(mem_if.mem_request), '0);
        check("drain seen", W'(seen.size()), 32'd5);
        for (int k = 0; k < 5; k++) check("drain order", seen[k], exp_seen[k]);

        // PC write and address wrap
        alu(PCI, 32'h2000, '0, 1'b0, 4'h0, 32'h500);
        check("pc write", output_registers[PCI*W +: W], 32'h2000);
        alu(1, 32'h8, '0, 1'b0, 4'h0, 32'h2004);
        seen.delete();
        store(0, 32'hFFFF_FFFC, 32'h11, 32'h2008, 1'b0);
        store(1, 32'hFFFF_FFFC, 32'h22, 32'h200C, 1'b0);
        for (int k = 0; k < 4; k++) idle(1'b1);
        check("wrap seen", W'(seen.size()), 32'd2);
        check("r0 base addr", seen[0], 32'hFFFF_FFFC);
        check("wrap addr", seen[1], 32'h4);

        // Reset with stores pending
        for (int k = 0; k < 3; k++) store(2, 32'(k), 32'h30 + 32'(k), 32'h3000 + 32'(k), 1'b0);
        check("pre-reset count", W'(queue_count), 32'd3);
        rf_in = exp_regs;
        drive(1'b0, 1'b0, 0, '0, '0, 1'b0, '0, 4'h0, 32'h4000, 1'b0, 1'b0);
        #2; reset_n = 1'b0; #1;
        sb.delete();
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        exp_flushed = 1'b0;
        check("mid reset request", W'(mem_if.mem_request), '0);
        check("mid reset count", W'(queue_count), '0);
        check_regs("mid reset");
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < NR; i++) rf_in[i] = $urandom;
            else
                rf_in = exp_regs;
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, NR - 1)),
                  $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom), $urandom,
                  1'($urandom), 1'($urandom));
            cycle("rand");
        end
        for (int k = 0; k < DEPTH + 2; k++) idle(1'b1);
        check("final scoreboard empty", W'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/write_queued.md
# write_queued

Writeback stage with a parametrised store queue, placed at the end of the pipeline after execute. Register results, including the optional upper half of a register pair, the flag field and the next PC, commit to the register file every accepted cycle. Memory stores are buffered in a FIFO of DEPTH entries and drained through a valid/accept handshake. The pipeline stalls only when the queue is full and no entry drains in the same cycle.

## Interface
- W, 32, register/data width
- NR, 32, number of registers
- DEPTH, 4, store queue entries (≥2, power of two)
- FLAGS_INDEX, NR-2, flags register index
- PC_INDEX, NR-1, program counter index
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- is_valid  in  1  execute presents an instruction
- hold  out  1  stall request to upstream
- destination_register  in  $clog2(NR)  target register, or base register for a store
- destination_value  in  W  result, or store data
- upper_value  in  W  value for destination_register+1
- has_upper_value  in  1  upper_value is meaningful
- is_writing_memory  in  1  instruction is a store
- adjustment_value  in  W  store address offset
- flags  in  4  new flag field, bits [30:27] of the flags register
- pc  in  W  PC of the current instruction
- next_pc  in  W  sequential next PC
- has_flushed_in  in  1  flush marker from execute
- has_flushed  out  1  registered flush marker
- input_registers  in  NR*W  current register file, flattened, reg i at [i*W +: W]
- output_registers  out  NR*W  registered next register file
- mem_request  out  1  queue head valid
- mem_address, mem_data  out  W  queue head address and data
- mem_accept  in  1  memory consumes the head this cycle
- queue_count  out  $clog2(DEPTH+1)  occupancy
- feedback_is_valid  out  1  forwarding result valid
- feedback_index  out  $clog2(NR)  forwarding target
- feedback_value, feedback_upper_value  out  W  forwarding data
- feedback_has_upper_value  out  1  upper forwarding valid

## Operation
- Working view, reg i:
  - i=0: 0.
  - i=PC_INDEX: pc.
  - i=FLAGS_INDEX: destination_value if destination_register=i and not a store, else {in[31], flags, in[26:0]}.
  - Other i: destination_value if destination_register=i and not a store; else upper_value if has_upper_value, i=destination_register+1 and not a store; else input_registers[i].
- The upper write never targets 0, FLAGS_INDEX or PC_INDEX. It is dropped when destination_register+1 ≥ NR.
- pop = mem_request && mem_accept. full = queue_count==DEPTH.
- hold = reset_n && is_valid && is_writing_memory && full && !mem_accept. A push is allowed in the same cycle as a pop when full.
- accepted = is_valid && !hold.
- A store enqueues {address = view[destination_register] + adjustment_value mod 2^W, data = destination_value} when accepted.
- Commit on an accepted cycle: output_registers ← view, then PC overwritten. has_flushed ← has_flushed_in.
- PC value: destination_value if dest=PC_INDEX and not a store, else next_pc. When is_valid=0, PC ← next_pc and has_flushed ← 0.
- While held, output_registers, PC and has_flushed keep their values.
- Feedback is combinational:
  - feedback_is_valid = is_valid && !is_writing_memory.
  - index/value/upper/has_upper pass through from the inputs.
- The FIFO has registered head/tail pointers and a count. Head fields are valid only while mem_request=1. Entries drain strictly in order.

## Timing
- Reset values: output_registers all 0, has_flushed 0, queue empty, mem_request 0, queue_count 0.
- Reset asserted mid-operation discards queued stores immediately.
- Register commit happens at the rising edge following the accepted cycle.
- Store enqueued at edge N is at the head (empty queue) with mem_request=1 from cycle N+1.
- Pop occurs at the edge where mem_request && mem_accept.
- Simultaneous push and pop leaves queue_count unchanged. Pointers wrap modulo DEPTH.
- mem_accept while mem_request=0 is ignored.
- hold is combinational from is_valid, is_writing_memory, full and mem_accept.

## Test plan
- Reset, then ALU write of 0x1234 to r5 with next_pc=0x104 -> after one edge r5=0x1234, PC=0x104, r0=0, queue_count=0.
- Pair write r6=0xA, upper 0xB -> r6=0xA, r7=0xB. Same with destination=FLAGS_INDEX-1 -> flags register unchanged except flags field.
- Four stores, base r2=0x100, offsets 0,4,8,12, mem_accept=0 -> queue_count=4. A fifth store asserts hold and r/PC stay frozen. Raising mem_accept pops 0x100 and accepts the fifth in the same cycle.
- Drain a full queue with mem_accept=1 -> addresses 0x100, 0x104, 0x108, 0x10C, 0x110 appear in order, mem_request falls after the last, count=0.
- Write destination_value 0x2000 to PC_INDEX -> PC=0x2000 next cycle, next_pc ignored. Base r0 store with offset 0xFFFFFFFC, base r1=8 -> address wraps to 4.
- Assert reset_n=0 with 3 entries queued -> mem_request=0, count=0 immediately, all registers 0.
